// File: rtl/adder_nbit_serial.sv
// adder_nbit_serial
//   Bit-serial add/subtract unit. One full-adder cell is reused for DATA_W
//   cycles, LSB first. Requests and results use valid/ready handshakes.
//
//   Ports
//     i_clk        sole clock, rising edge
//     i_rst_n      asynchronous active-low reset
//     i_req_valid  request operands valid
//     o_req_ready  block can accept a request (IDLE only)
//     i_num_a      operand a
//     i_num_b      operand b
//     i_sub        1 = a-b, 0 = a+b+i_cry
//     i_cry        carry-in for add, ignored for subtract
//     o_res_valid  result valid (DONE)
//     i_res_ready  consumer accepts result
//     o_res        sum/difference modulo 2^DATA_W
//     o_cry        unsigned carry-out (subtract: 1 = no borrow)
//     o_ovf        two's-complement overflow
//     o_busy       high while an operation is in progress or held
//
//   Also contains adder_01bit_full, the 1-bit full adder cell.

module adder_01bit_full (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; last result still on the outputs
// CALC  | one bit per cycle through the full-adder cell, LSB first
// DONE  | result presented, held until the consumer takes it
module adder_nbit_serial #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [DATA_W-1:0] i_num_a,
    input  logic [DATA_W-1:0] i_num_b,
    input  logic              i_sub,
    input  logic              i_cry,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [DATA_W-1:0] o_res,
    output logic              o_cry,
    output logic              o_ovf,
    output logic              o_busy
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic [DATA_W-1:0] acc_q,     acc_d;
    logic              cry_q,     cry_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] res_out_q, res_out_d;
    logic              cry_out_q, cry_out_d;
    logic              ovf_out_q, ovf_out_d;

    logic fa_s;
    logic fa_co;

    adder_01bit_full u_fa (
        .i_a  (a_q[0]),
        .i_b  (b_q[0]),
        .i_ci (cry_q),
        .o_s  (fa_s),
        .o_co (fa_co)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cry_q     <= 1'b0;
            cnt_q     <= '0;
            res_out_q <= '0;
            cry_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cry_q     <= cry_d;
            cnt_q     <= cnt_d;
            res_out_q <= res_out_d;
            cry_out_q <= cry_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cry_d     = cry_q;
        cnt_d     = cnt_q;
        res_out_d = res_out_q;
        cry_out_d = cry_out_q;
        ovf_out_d = ovf_out_q;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    state_d = S_CALC;
                    a_d     = i_num_a;
                    // Subtract as a + ~b + 1.
                    b_d     = i_sub ? ~i_num_b : i_num_b;
                    cry_d   = i_sub ? 1'b1 : i_cry;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                acc_d = {fa_s, acc_q[DATA_W-1:1]};
                cry_d = fa_co;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // cry_q is the carry into the MSB, fa_co the carry out of it.
                    state_d   = S_DONE;
                    res_out_d = {fa_s, acc_q[DATA_W-1:1]};
                    cry_out_d = fa_co;
                    ovf_out_d = cry_q ^ fa_co;
                end
            end
            S_DONE: begin
                if (i_res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_res_valid = (state_q == S_DONE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_res       = res_out_q;
    assign o_cry       = cry_out_q;
    assign o_ovf       = ovf_out_q;

endmodule

// File: tb/tb_adder_nbit_serial.sv
module tb_adder_nbit_serial;
    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_req_valid = 1'b0;
    logic         o_req_ready;
    logic [W-1:0] i_num_a = '0;
    logic [W-1:0] i_num_b = '0;
    logic         i_sub = 1'b0;
    logic         i_cry = 1'b0;
    logic         o_res_valid;
    logic         i_res_ready = 1'b0;
    logic [W-1:0] o_res;
    logic         o_cry;
    logic         o_ovf;
    logic         o_busy;

    int n_checks = 0;
    int n_err    = 0;

    adder_nbit_serial #(.DATA_W(W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_num_a     (i_num_a),
        .i_num_b     (i_num_b),
        .i_sub       (i_sub),
        .i_cry       (i_cry),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res       (o_res),
        .o_cry       (o_cry),
        .o_ovf       (o_ovf),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin,
                                  output logic [W-1:0] r, output logic c, output logic o);
        int ua, ub, ur, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            c  = (ur >= (1 << W));
        end
        r = ur[W-1:0];
        o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    endfunction

    task automatic scramble();
        i_num_a     = W'($urandom);
        i_num_b     = W'($urandom);
        i_sub       = 1'($urandom);
        i_cry       = 1'($urandom);
        i_req_valid = 1'($urandom);
    endtask

    // Entered and left at a falling edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin,
                         input int pre, input int stall,
                         output logic [W-1:0] r, output logic c, output logic o);
        int g;
        int lat;
        bit done;
        for (int i = 0; i < pre; i++) begin
            i_req_valid = 1'b0;
            @(negedge i_clk);
        end
        g = 0;
        while (!o_req_ready && g < 20) begin
            @(negedge i_clk);
            g++;
        end
        chk("req_ready_idle", 64'(o_req_ready), 64'd1);
        i_req_valid = 1'b1;
        i_num_a     = a;
        i_num_b     = b;
        i_sub       = sub;
        i_cry       = cin;
        i_res_ready = 1'b0;
        @(posedge i_clk);
        #1 scramble();
        lat  = 0;
        done = 0;
        while (!done && lat < 4 * W) begin
            @(posedge i_clk);
            lat++;
            #1 scramble();
            @(negedge i_clk);
            if (o_res_valid) done = 1;
            else chk("calc_ready_busy", 64'({o_req_ready, o_busy}), 64'b01);
        end
        chk("latency", 64'(lat), 64'(W));
        chk("done_ready_busy", 64'({o_req_ready, o_busy}), 64'b01);
        r = o_res;
        c = o_cry;
        o = o_ovf;
        for (int s = 0; s < stall; s++) begin
            i_res_ready = 1'b0;
            scramble();
            i_req_valid = 1'b1;
            @(posedge i_clk);
            @(negedge i_clk);
            chk("done_hold", 64'({o_res_valid, o_req_ready, o_res, o_cry, o_ovf}),
                64'({1'b1, 1'b0, r, c, o}));
        end
        i_res_ready = 1'b1;
        scramble();
        i_req_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_res_ready = 1'b0;
        i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("idle_after_release", 64'({o_res_valid, o_busy, o_req_ready}), 64'b001);
        chk("idle_result_hold", 64'({o_res, o_cry, o_ovf}), 64'({r, c, o}));
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin, input int stall,
                            input logic [W-1:0] xr, input logic xc, input logic xo);
        logic [W-1:0] r, mr;
        logic c, o, mc, mo;
        do_op(a, b, sub, cin, 0, stall, r, c, o);
        model(a, b, sub, cin, mr, mc, mo);
        chk({tag, "_res"}, 64'(r), 64'(xr));
        chk({tag, "_cry"}, 64'(c), 64'(xc));
        chk({tag, "_ovf"}, 64'(o), 64'(xo));
        chk({tag, "_model"}, 64'({mr, mc, mo}), 64'({xr, xc, xo}));
    endtask

    initial begin
        logic [W-1:0] ra, rb, r, mr;
        logic rs, rc, c, o, mc, mo;

        #1;
        chk("reset_outputs", 64'({o_req_ready, o_res_valid, o_busy, o_res, o_cry, o_ovf}),
            64'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));
        #20;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        directed("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 0, 8'h8D, 1'b0, 1'b1);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1, 8'h00, 1'b1, 1'b0);
        directed("add_7f_00_c", 8'h7F, 8'h00, 1'b0, 1'b1, 0, 8'h80, 1'b0, 1'b1);
        directed("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, 0, 8'hF0, 1'b0, 1'b0);
        directed("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 5, 8'h7F, 1'b1, 1'b1);

        // Abort in the third CALC cycle.
        i_req_valid = 1'b1;
        i_num_a     = 8'hAA;
        i_num_b     = 8'h55;
        i_sub       = 1'b0;
        i_cry       = 1'b0;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midcalc_reset", 64'({o_req_ready, o_res_valid, o_busy, o_res, o_cry, o_ovf}),
            64'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));
        @(negedge i_clk);
        chk("reset_held", 64'({o_req_ready, o_res_valid, o_busy, o_res}),
            64'({1'b1, 1'b0, 1'b0, 8'h00}));
        i_rst_n = 1'b1;
        directed("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rs, rc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), r, c, o);
            model(ra, rb, rs, rc, mr, mc, mo);
            chk("rand_result", 64'({r, c, o}), 64'({mr, mc, mo}));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
